// File: rtl/full_add_behavioral.sv
// Registered WIDTH-bit ripple-carry full adder: {cout,s} = a + b + cin, one cycle latency.
// Define FA_OVF_EN to add the registered signed-overflow output ovf.
module full_add_behavioral #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
`ifdef FA_OVF_EN
    ,output logic            ovf
`endif
);

    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             valid_q;
`ifdef FA_OVF_EN
    logic             ovf_d, ovf_q;
`endif

    // Ripple chain: the carry is a loop-carried variable, so each cell sees its predecessor's carry.
    always_comb begin : ripple
        logic c;
`ifdef FA_OVF_EN
        logic c_prev;
`endif
        // NOTE: every variable written here gets a value before any branch or loop, so no latch is inferred.
        sum_d = '0;
        c     = cin;
`ifdef FA_OVF_EN
        c_prev = cin;
`endif
        for (int i = 0; i < WIDTH; i++) begin
`ifdef FA_OVF_EN
            c_prev = c;
`endif
            sum_d[i] = a[i] ^ b[i] ^ c;
            c        = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout_d = c;
`ifdef FA_OVF_EN
        // Carry into the sign bit differs from carry out of it: signed overflow.
        ovf_d = c ^ c_prev;
`endif
    end

    // NOTE: registered state uses non-blocking assignments; the combinational ripple above uses blocking ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef FA_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= in_valid;
            // Result registers only load on a valid input, so idle-cycle X/Z never reaches them.
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef FA_OVF_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign s         = sum_q;
    assign cout      = cout_q;
    assign out_valid = valid_q;
`ifdef FA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_add_behavioral.sv
// Self-checking bench for full_add_behavioral: a 1-bit and an 8-bit instance checked
// against an arithmetic reference model, with directed corner cases then random traffic.
module tb_full_add_behavioral;

    logic       clk = 1'b0;
    logic       rst;
    logic       v1, a1, b1, c1;
    logic       s1, co1, vo1;
    logic       v8, c8;
    logic [7:0] a8, b8;
    logic [7:0] s8;
    logic       co8, vo8;
`ifdef FA_OVF_EN
    logic       ov1, ov8;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state: what each DUT should present after the next edge.
    logic       m1_s, m1_c, m1_v, m1_o;
    logic [7:0] m8_s;
    logic       m8_c, m8_v, m8_o;

    always #5 clk = ~clk;

    full_add_behavioral #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .cin(c1),
        .s(s1), .cout(co1), .out_valid(vo1)
`ifdef FA_OVF_EN
        , .ovf(ov1)
`endif
    );

    full_add_behavioral #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .cin(c8),
        .s(s8), .cout(co8), .out_valid(vo8)
`ifdef FA_OVF_EN
        , .ovf(ov8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model from the currently driven inputs, clock once, compare both DUTs.
    task automatic cycle();
        logic [1:0] t1;
        logic [8:0] t8;
        int         sg;
        if (rst) begin
            m1_s = 1'b0; m1_c = 1'b0; m1_v = 1'b0; m1_o = 1'b0;
            m8_s = '0;   m8_c = 1'b0; m8_v = 1'b0; m8_o = 1'b0;
        end else begin
            m1_v = v1;
            if (v1) begin
                t1 = 2'(a1) + 2'(b1) + 2'(c1);
                {m1_c, m1_s} = t1;
                sg = (a1 ? -1 : 0) + (b1 ? -1 : 0) + int'(c1);
                m1_o = (sg > 0) || (sg < -1);
            end
            m8_v = v8;
            if (v8) begin
                t8 = 9'(a8) + 9'(b8) + 9'(c8);
                {m8_c, m8_s} = t8;
                sg = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
                m8_o = (sg > 127) || (sg < -128);
            end
        end
        @(posedge clk);
        #1;
        check("w1_s",     64'(s1),  64'(m1_s));
        check("w1_cout",  64'(co1), 64'(m1_c));
        check("w1_valid", 64'(vo1), 64'(m1_v));
        check("w8_s",     64'(s8),  64'(m8_s));
        check("w8_cout",  64'(co8), 64'(m8_c));
        check("w8_valid", 64'(vo8), 64'(m8_v));
`ifdef FA_OVF_EN
        check("w1_ovf",   64'(ov1), 64'(m1_o));
        check("w8_ovf",   64'(ov8), 64'(m8_o));
`endif
    endtask

    initial begin
        logic [1:0] fa_tab [8];
        logic [2:0] abc;
        fa_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

        // Reset with nothing valid.
        rst = 1'b1;
        v1 = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b0; a8 = '0;   b8 = '0;   c8 = 1'b0;
        #2;
        cycle();
        check("rst_s8",     64'(s8),  64'h0);
        check("rst_cout8",  64'(co8), 64'h0);
        check("rst_valid8", 64'(vo8), 64'h0);
        check("rst_valid1", 64'(vo1), 64'h0);
        rst = 1'b0;

        // 1-bit truth table, back-to-back.
        for (int i = 0; i < 8; i++) begin
            abc = 3'(i);
            v1 = 1'b1;
            {a1, b1, c1} = abc;
            cycle();
            check("tt_sum", 64'({co1, s1}), 64'(fa_tab[i]));
            check("tt_valid", 64'(vo1), 64'h1);
        end
        v1 = 1'b0;

        // 8-bit carry extremes.
        v8 = 1'b1; a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1;
        cycle();
        check("ff00_s", 64'(s8), 64'h00);
        check("ff00_cout", 64'(co8), 64'h1);
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
        cycle();
        check("ffff_s", 64'(s8), 64'hFF);
        check("ffff_cout", 64'(co8), 64'h1);

        // Hold after a valid result, with idle garbage on the inputs.
        a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
        cycle();
        check("hold_s0", 64'(s8), 64'h46);
        check("hold_v0", 64'(vo8), 64'h1);
        v8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a8 = 8'(i * 37 + 5); b8 = 8'hA5; c8 = 1'b1;
            cycle();
            check("hold_s", 64'(s8), 64'h46);
            check("hold_cout", 64'(co8), 64'h0);
            check("hold_v", 64'(vo8), 64'h0);
        end

        // Reset beats a simultaneous valid; next valid behaves normally.
        rst = 1'b1; v8 = 1'b1; a8 = 8'h01; b8 = 8'h01; c8 = 1'b0;
        cycle();
        check("rstpri_s", 64'(s8), 64'h00);
        check("rstpri_v", 64'(vo8), 64'h0);
        rst = 1'b0;
        cycle();
        check("post_rst_s", 64'(s8), 64'h02);
        check("post_rst_v", 64'(vo8), 64'h1);

`ifdef FA_OVF_EN
        a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
        cycle();
        check("ovf_pos_s", 64'(s8), 64'h80);
        check("ovf_pos_o", 64'(ov8), 64'h1);
        check("ovf_pos_c", 64'(co8), 64'h0);
        a8 = 8'h80; b8 = 8'h80; c8 = 1'b0;
        cycle();
        check("ovf_neg_s", 64'(s8), 64'h00);
        check("ovf_neg_c", 64'(co8), 64'h1);
        check("ovf_neg_o", 64'(ov8), 64'h1);
`endif

        // Random traffic with occasional idle cycles and mid-stream resets.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            v1  = ($urandom_range(0, 3) != 0);
            a1  = 1'($urandom);
            b1  = 1'($urandom);
            c1  = 1'($urandom);
            v8  = ($urandom_range(0, 3) != 0);
            a8  = 8'($urandom);
            b8  = 8'($urandom);
            c8  = 1'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
